frame_renderer: RTL and testbench

Parametrised, double-buffered successor to the fixed single-frame graphics driver. Each frame, the block snapshots a background colour and up to `NUM_RECTS` rectangle descriptors. It rasterises them one pixel per clock into the back half of an external two-bank frame buffer, and swaps banks on `refresh` only when rendering is complete. It sits between game logic (rectangle producers) and the VGA scan-out, which reads the bank selected by `front_sel`.

---
 rtl/graphics_pkg.sv | 27 ++
 rtl/frame_renderer_if.sv | 43 ++++
 rtl/rect_compositor.sv | 28 ++
 rtl/frame_renderer.sv | 139 +++++++++++++
 tb/tb_frame_renderer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared graphics constants, rectangle descriptor and renderer state
package graphics_pkg;

  localparam int DEF_H_RES     = 160;
  localparam int DEF_V_RES     = 120;
  localparam int DEF_COLOR_W   = 4;
  localparam int DEF_NUM_RECTS = 4;
  localparam int PIX_W         = 3 * DEF_COLOR_W;
  localparam int RECT_X_W      = $clog2(DEF_H_RES);
  localparam int RECT_Y_W      = $clog2(DEF_V_RES);

  typedef struct packed {
    logic                en;
    logic [RECT_X_W-1:0] x;
    logic [RECT_Y_W-1:0] y;
    logic [RECT_X_W-1:0] w;
    logic [RECT_Y_W-1:0] h;
    logic [PIX_W-1:0]    color;
  } rect_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RENDER = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/frame_renderer_if.sv
// rtl/frame_renderer_if.sv - rectangle/background inputs, frame-buffer write port and status of the renderer
interface frame_renderer_if
  import graphics_pkg::*;
#(
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int NUM_RECTS = DEF_NUM_RECTS
);

  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = $clog2(V_RES);
  localparam int PW  = 3 * COLOR_W;

  logic                            refresh;
  logic [PW-1:0]                   bg_color;
  logic [NUM_RECTS-1:0]            rect_en;
  logic [NUM_RECTS-1:0][X_W-1:0]   rect_x;
  logic [NUM_RECTS-1:0][Y_W-1:0]   rect_y;
  logic [NUM_RECTS-1:0][X_W-1:0]   rect_w;
  logic [NUM_RECTS-1:0][Y_W-1:0]   rect_h;
  logic [NUM_RECTS-1:0][PW-1:0]    rect_color;

  logic                            wr_en;
  logic                            wr_bank;
  logic [X_W-1:0]                  wr_x;
  logic [Y_W-1:0]                  wr_y;
  logic [PW-1:0]                   wr_data;
  logic                            front_sel;
  logic                            busy;
  logic [15:0]                     drop_cnt;

  modport master (
    input  refresh, bg_color, rect_en, rect_x, rect_y, rect_w, rect_h, rect_color,
    output wr_en, wr_bank, wr_x, wr_y, wr_data, front_sel, busy, drop_cnt
  );

  modport slave (
    output refresh, bg_color, rect_en, rect_x, rect_y, rect_w, rect_h, rect_color,
    input  wr_en, wr_bank, wr_x, wr_y, wr_data, front_sel, busy, drop_cnt
  );

endinterface

// File: rtl/rect_compositor.sv
// rtl/rect_compositor.sv - combinational priority hit-test of snapshotted rectangles at one pixel
module rect_compositor
  import graphics_pkg::*;
#(
  parameter int NUM_RECTS = DEF_NUM_RECTS
) (
  input  rect_t [NUM_RECTS-1:0] rects,
  input  logic  [RECT_X_W-1:0]  x,
  input  logic  [RECT_Y_W-1:0]  y,
  input  logic  [PIX_W-1:0]     bg_color,
  output logic  [PIX_W-1:0]     color
);

  // later slots overwrite earlier hits; far edges carry one extra bit so they never wrap
  always_comb begin
    color = bg_color;
    for (int i = 0; i < NUM_RECTS; i++) begin
      if (rects[i].en &&
          ({1'b0, x} >= {1'b0, rects[i].x}) &&
          ({1'b0, x} <  ({1'b0, rects[i].x} + {1'b0, rects[i].w})) &&
          ({1'b0, y} >= {1'b0, rects[i].y}) &&
          ({1'b0, y} <  ({1'b0, rects[i].y} + {1'b0, rects[i].h}))) begin
        color = rects[i].color;
      end
    end
  end

endmodule

// File: rtl/frame_renderer.sv
// rtl/frame_renderer.sv - double-buffered rectangle rasteriser; FRAME_RENDERER_DROP_CNT_EN enables the drop counter
module frame_renderer
  import graphics_pkg::*;
#(
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int NUM_RECTS = DEF_NUM_RECTS
) (
  input  logic             clk,
  input  logic             rst,
  frame_renderer_if.master bus
);

  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = $clog2(V_RES);
  localparam int PW  = 3 * COLOR_W;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  state_t                 state, state_n;
  logic                   do_snap, do_swap, do_emit;
  logic [X_W-1:0]         cx;
  logic [Y_W-1:0]         cy;
  logic                   scan_done;
  rect_t [NUM_RECTS-1:0]  snap_rects;
  logic [PW-1:0]          snap_bg;
  logic [PW-1:0]          pix_color;
  logic                   front_n;

  rect_compositor #(.NUM_RECTS(NUM_RECTS)) u_comp (
    .rects    (snap_rects),
    .x        (cx),
    .y        (cy),
    .bg_color (snap_bg),
    .color    (pix_color)
  );

  // next state; RENDER lingers one cycle after the last pixel so its write drains before DONE
  always_comb begin
    state_n = state;
    do_snap = 1'b0;
    do_swap = 1'b0;
    do_emit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.refresh) begin
          state_n = RENDER;
          do_snap = 1'b1;
        end
      end
      RENDER: begin
        if (scan_done) state_n = DONE;
        else           do_emit = 1'b1;
      end
      DONE: begin
        if (bus.refresh) begin
          state_n = RENDER;
          do_snap = 1'b1;
          do_swap = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    front_n = do_swap ? ~bus.front_sel : bus.front_sel;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // frame snapshot and raster scan counters (x fastest)
  always_ff @(posedge clk) begin
    if (rst) begin
      cx         <= '0;
      cy         <= '0;
      scan_done  <= 1'b0;
      snap_rects <= '0;
      snap_bg    <= '0;
    end else if (do_snap) begin
      cx        <= '0;
      cy        <= '0;
      scan_done <= 1'b0;
      snap_bg   <= bus.bg_color;
      for (int i = 0; i < NUM_RECTS; i++) begin
        snap_rects[i] <= '{en: bus.rect_en[i], x: bus.rect_x[i], y: bus.rect_y[i],
                           w: bus.rect_w[i], h: bus.rect_h[i], color: bus.rect_color[i]};
      end
    end else if (do_emit) begin
      if (cx == X_LAST) begin
        cx <= '0;
        if (cy == Y_LAST) scan_done <= 1'b1;
        else              cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  // registered write port, bank select and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_en     <= 1'b0;
      bus.wr_x      <= '0;
      bus.wr_y      <= '0;
      bus.wr_data   <= '0;
      bus.front_sel <= 1'b0;
      bus.wr_bank   <= 1'b1;
      bus.busy      <= 1'b0;
    end else begin
      bus.wr_en     <= do_emit;
      bus.front_sel <= front_n;
      bus.wr_bank   <= ~front_n;
      bus.busy      <= (state_n == RENDER);
      if (do_emit) begin
        bus.wr_x    <= cx;
        bus.wr_y    <= cy;
        bus.wr_data <= pix_color;
      end
    end
  end

`ifdef FRAME_RENDERER_DROP_CNT_EN
  logic [15:0] drop_q;

  // saturating count of refreshes that arrive while a frame is still rendering
  always_ff @(posedge clk) begin
    if (rst)                                                 drop_q <= '0;
    else if (bus.refresh && state == RENDER && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign bus.drop_cnt = drop_q;
`else
  assign bus.drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_frame_renderer.sv
// tb/tb_frame_renderer.sv - self-checking bench for frame_renderer against a rectangle priority model
module tb_frame_renderer;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int NR = 4;
  localparam int N  = H * V;

  logic clk;
  logic rst;

  int vectors = 0;
  int errs    = 0;
  int exp_drop = 0;

  int          s_en  [NR];
  int          s_x   [NR];
  int          s_y   [NR];
  int          s_w   [NR];
  int          s_h   [NR];
  logic [11:0] s_col [NR];
  logic [11:0] s_bg;
  logic [11:0] fb [0:V-1][0:H-1];

  frame_renderer_if #(.H_RES(H), .V_RES(V), .COLOR_W(4), .NUM_RECTS(NR)) bus ();

  frame_renderer #(.H_RES(H), .V_RES(V), .COLOR_W(4), .NUM_RECTS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // reference: highest enabled slot whose half-open box contains the pixel, else background
  function automatic logic [11:0] ref_pixel(input int x, input int y);
    for (int s = NR - 1; s >= 0; s--) begin
      if (s_en[s] != 0 && x >= s_x[s] && x < s_x[s] + s_w[s] &&
          y >= s_y[s] && y < s_y[s] + s_h[s])
        return s_col[s];
    end
    return s_bg;
  endfunction

  function automatic logic [15:0] drop_exp();
`ifdef FRAME_RENDERER_DROP_CNT_EN
    return 16'(exp_drop);
`else
    return 16'd0;
`endif
  endfunction

  task automatic set_rect(input int s, input int en, input int x, input int y,
                          input int w, input int h, input logic [11:0] c);
    bus.rect_en[s]    = en[0];
    bus.rect_x[s]     = 8'(x);
    bus.rect_y[s]     = 7'(y);
    bus.rect_w[s]     = 8'(w);
    bus.rect_h[s]     = 7'(h);
    bus.rect_color[s] = c;
  endtask

  task automatic scramble();
    for (int s = 0; s < NR; s++)
      set_rect(s, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 12'($urandom));
    bus.bg_color = 12'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   64'(bus.wr_en),     64'd0);
    chk({tag, "_busy"},    64'(bus.busy),      64'd0);
    chk({tag, "_front"},   64'(bus.front_sel), 64'd0);
    chk({tag, "_bank"},    64'(bus.wr_bank),   64'd1);
    chk({tag, "_drop"},    64'(bus.drop_cnt),  64'd0);
    chk({tag, "_wr_x"},    64'(bus.wr_x),      64'd0);
    chk({tag, "_wr_y"},    64'(bus.wr_y),      64'd0);
    chk({tag, "_wr_data"}, 64'(bus.wr_data),   64'd0);
  endtask

  // one frame: refresh pulse, then every cycle of the write burst compared against the model
  task automatic run_frame(input logic exp_front, input bit drops, input int rst_idx, input int stop_idx);
    int nwr;
    int ex;
    int ey;
    logic [63:0] obs;
    logic [63:0] expv;
    for (int s = 0; s < NR; s++) begin
      s_en[s]  = int'(bus.rect_en[s]);
      s_x[s]   = int'(bus.rect_x[s]);
      s_y[s]   = int'(bus.rect_y[s]);
      s_w[s]   = int'(bus.rect_w[s]);
      s_h[s]   = int'(bus.rect_h[s]);
      s_col[s] = bus.rect_color[s];
    end
    s_bg = bus.bg_color;
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
    chk("start_busy",  64'(bus.busy),      64'd1);
    chk("start_front", 64'(bus.front_sel), 64'(exp_front));
    chk("start_wr_en", 64'(bus.wr_en),     64'd0);
    scramble();
    nwr = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      ex = i % H;
      ey = i / H;
      nwr += int'(bus.wr_en);
      obs  = {17'd0, bus.wr_en, bus.wr_bank, bus.front_sel, bus.busy, bus.drop_cnt,
              bus.wr_x, bus.wr_y, bus.wr_data};
      expv = {17'd0, 1'b1, ~exp_front, exp_front, 1'b1, drop_exp(), 8'(ex), 7'(ey), ref_pixel(ex, ey)};
      chk($sformatf("pix(%0d,%0d)", ex, ey), obs, expv);
      fb[ey][ex] = bus.wr_data;
      if (i == rst_idx) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_drop = 0;
        check_reset_outputs("abort");
        return;
      end
      if (i == stop_idx) return;
      if (drops && (i % 1000 == 500 || i == N - 2 || i == N - 1)) begin
        bus.refresh = 1'b1;
        exp_drop++;
      end else begin
        bus.refresh = 1'b0;
      end
    end
    @(negedge clk);
    bus.refresh = 1'b0;
    chk("writes",    64'(nwr),           64'(N));
    chk("end_wr_en", 64'(bus.wr_en),     64'd0);
    chk("end_busy",  64'(bus.busy),      64'd0);
    chk("end_front", 64'(bus.front_sel), 64'(exp_front));
    chk("end_drop",  64'(bus.drop_cnt),  64'(drop_exp()));
  endtask

  initial begin
    rst = 1'b1;
    bus.refresh    = 1'b0;
    bus.bg_color   = '0;
    bus.rect_en    = '0;
    bus.rect_x     = '0;
    bus.rect_y     = '0;
    bus.rect_w     = '0;
    bus.rect_h     = '0;
    bus.rect_color = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy",  64'(bus.busy),  64'd0);
    chk("idle_wr_en", 64'(bus.wr_en), 64'd0);

    // frame 1: background only, from IDLE so no swap and bank 1 is written
    scramble();
    bus.rect_en  = '0;
    bus.bg_color = 12'h00F;
    run_frame(1'b0, 1'b0, -1, -1);
    chk("f1_first", 64'(fb[0][0]),     64'h00F);
    chk("f1_last",  64'(fb[V-1][H-1]), 64'h00F);

    // frame 2: issued at the shortest non-dropping period; small rect, edge clip, zero-size slot
    bus.bg_color = 12'h123;
    set_rect(0, 1, 10, 20, 5, 3, 12'hF00);
    set_rect(1, 1, int'($urandom_range(60, 100)), int'($urandom_range(30, 60)),
             int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 12'($urandom));
    set_rect(2, 1, 155, 118, 20, 10, 12'h5A5);
    set_rect(3, 1, 0, 0, 0, 5, 12'hABC);
    run_frame(1'b1, 1'b0, -1, -1);
    chk("r0_tl",      64'(fb[20][10]),  64'hF00);
    chk("r0_br",      64'(fb[22][14]),  64'hF00);
    chk("r0_right",   64'(fb[20][15]),  64'h123);
    chk("r0_below",   64'(fb[23][10]),  64'h123);
    chk("r0_left",    64'(fb[20][9]),   64'h123);
    chk("edge_tl",    64'(fb[118][155]), 64'h5A5);
    chk("edge_br",    64'(fb[119][159]), 64'h5A5);
    chk("edge_left",  64'(fb[118][154]), 64'h123);
    chk("nowrap_0",   64'(fb[118][0]),  64'h123);
    chk("nowrap_4",   64'(fb[119][4]),  64'h123);
    chk("zero_w",     64'(fb[0][0]),    64'h123);

    // frame 3: overlapping slots 0 and 3, refresh pulses mid-render must not swap
    bus.bg_color = 12'h000;
    set_rect(0, 1, 50, 50, 20, 20, 12'h0F0);
    set_rect(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 30)), int'($urandom_range(0, 30)),
             int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 12'($urandom));
    set_rect(2, int'($urandom_range(0, 1)), int'($urandom_range(0, 30)), int'($urandom_range(0, 30)),
             int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 12'($urandom));
    set_rect(3, 1, 50, 50, 10, 10, 12'hFFF);
    run_frame(1'b0, 1'b1, -1, -1);
    chk("ovl_tl",   64'(fb[50][50]), 64'hFFF);
    chk("ovl_br",   64'(fb[59][59]), 64'hFFF);
    chk("low_only", 64'(fb[50][60]), 64'h0F0);
    chk("low_br",   64'(fb[69][69]), 64'h0F0);
    chk("ovl_out",  64'(fb[70][70]), 64'h000);

    // frame 4: fully random slots, reset at pixel (80,60)
    scramble();
    run_frame(1'b1, 1'b0, 60 * H + 80, -1);
    repeat (3) @(negedge clk);
    chk("post_rst_busy",  64'(bus.busy),  64'd0);
    chk("post_rst_wr_en", 64'(bus.wr_en), 64'd0);

    // frame 5: restart from IDLE at (0,0), bank 1, no swap
    scramble();
    run_frame(1'b0, 1'b0, -1, 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
